gf_sqr_seq: RTL

- Sequencer for the combinational GF(2^163) squarer `gf_Square`. Computes A^(2^k) by iterating one squaring per clock through a single accumulator register.
- Serves the Itoh-Tsujii inversion and point-arithmetic control in the ECDH engine, which need multi-squaring runs (k up to 255).
- Provides a start/done handshake toward the ECC top-level controller.

---
 rtl/gf_pkg.sv | 19 +
 rtl/gf_Square.sv | 28 ++
 rtl/gf_sqr_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^163) field types and constants for the squaring sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gf_pkg;

    localparam int NUM_BITS = 163;

    typedef logic [NUM_BITS:0] gf_elem_t;

    // f(x) = x^163 + x^7 + x^6 + x^3 + 1
    localparam gf_elem_t GF_POLY = (gf_elem_t'(1) << NUM_BITS) | gf_elem_t'(8'hC9);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sqr_state_t;

endpackage

// File: rtl/gf_Square.sv
// Combinational GF(2^163) squarer: bit spread followed by reduction modulo f(x).
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module gf_Square
    import gf_pkg::*;
(
    input  gf_elem_t A,
    output gf_elem_t Squared
);

    logic [2*NUM_BITS:0] prod;

    always_comb begin
        prod = '0;
        // Squaring in characteristic 2 only interleaves zeros between the operand bits.
        for (int i = 0; i <= NUM_BITS; i++) begin
            prod[2*i] = A[i];
        end
        // Fold from the top down so bits introduced by one fold are cleared by a later one.
        for (int i = 2*NUM_BITS; i >= NUM_BITS; i--) begin
            if (prod[i]) begin
                prod[i-NUM_BITS +: NUM_BITS+1] = prod[i-NUM_BITS +: NUM_BITS+1] ^ GF_POLY;
            end
        end
        Squared = prod[NUM_BITS:0];
    end

endmodule

// File: rtl/gf_sqr_seq.sv
// Multi-squaring sequencer: result = A^(2^k) using one squarer and one accumulator.
// Latency: done pulses in the cycle k edges after the accept edge (k+1 edges counting the accept edge).
// Backpressure: start is taken only while ready; starts in RUN or DONE are dropped.
module gf_sqr_seq
    import gf_pkg::*;
#(
    parameter int NUM_BITS = 163,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS:0]   A,
    input  logic [CNT_W-1:0]    k,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS:0]   result
);

    sqr_state_t          state;
    logic [NUM_BITS:0]   acc;
    logic [NUM_BITS:0]   acc_sq;
    logic [CNT_W-1:0]    cnt;

    // The squarer sees only the accumulator, never the raw operand.
    gf_Square u_sq (
        .A       (acc),
        .Squared (acc_sq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= A;
                        cnt   <= k;
                        ready <= 1'b0;
                        if (k != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= A;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_sq;
                    // Leave on the last squaring so cnt bottoms out at 1 and never wraps.
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_sq;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
